// File: rtl/patbuf_pkg.sv
//==============================================================================
// Module      : patbuf_pkg
// Description : Shared definitions for the pattern-buffer access arbiter:
//               buffer geometry defaults, requester IDs and the read-return
//               tag carried alongside each outstanding access.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package patbuf_pkg;

  localparam int BUFFER_SIZE  = 18;  // fields per buffer
  localparam int NO_BUFS      = 8;   // number of buffers
  localparam int BUFFER_WIDTH = 8;   // field data width

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  // One entry per granted access: valid marks a read that owes a response,
  // err marks an out-of-range access whose response data is forced to zero.
  typedef struct packed {
    logic valid;
    logic req_id;
    logic err;
  } rtag_t;

endpackage

`default_nettype wire

// File: rtl/patbuf_access_arbiter_if.sv
//==============================================================================
// Module      : patbuf_access_arbiter_if
// Description : Requester-side field access port of the pattern-buffer
//               arbiter. One instance per requester (pat core, host loader).
//   req        requester -> arbiter  access request, held until gnt
//   we         requester -> arbiter  1 = write, 0 = read
//   buf_idx    requester -> arbiter  buffer index (3 bits)
//   field_idx  requester -> arbiter  field index (5 bits)
//   wdata      requester -> arbiter  write data
//   gnt        arbiter -> requester  combinational grant
//   rvalid     arbiter -> requester  read data valid, 1-cycle pulse
//   rdata      arbiter -> requester  read data (0 when rvalid is low)
// Modports    : master = requester side, slave = arbiter side
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface patbuf_access_arbiter_if #(
  parameter int BUFFER_WIDTH = patbuf_pkg::BUFFER_WIDTH
);

  logic                    req;
  logic                    we;
  logic [2:0]              buf_idx;
  logic [4:0]              field_idx;
  logic [BUFFER_WIDTH-1:0] wdata;
  logic                    gnt;
  logic                    rvalid;
  logic [BUFFER_WIDTH-1:0] rdata;

  modport master (
    output req, we, buf_idx, field_idx, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, buf_idx, field_idx, wdata,
    output gnt, rvalid, rdata
  );

endinterface

`default_nettype wire

// File: rtl/patbuf_access_arbiter_rtag_pipe.sv
//==============================================================================
// Module      : patbuf_rtag_pipe
// Description : Fixed-depth shift register of read-return tags. A tag
//               entering on tag_in appears on tag_out DEPTH cycles later.
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset, empties the pipe
//   tag_in   in   tag for the access granted this cycle
//   tag_out  out  tag whose response is due this cycle
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module patbuf_rtag_pipe
  import patbuf_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic  clk,
  input  logic  reset_n,
  input  rtag_t tag_in,
  output rtag_t tag_out
);

  rtag_t stage [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/patbuf_access_arbiter.sv
//==============================================================================
// Module      : patbuf_access_arbiter
// Description : Shares the single field read/write port of the pattern
//               buffer between the pat core (normal priority) and the host
//               configuration loader (starvation-protected after MAX_WAIT
//               lost cycles). Bus outputs are registered, every access is
//               range-checked, and read data is routed back to its issuer
//               READ_LATENCY+1 cycles after the grant.
//   clk              in   clock, rising edge
//   reset_n          in   asynchronous active-low reset
//   core             if   pat core request port (slave modport)
//   host             if   host loader request port (slave modport)
//   range_err        out  registered pulse: granted access was out of range
//   bufp_out         out  buffer pointer to pattern buffer
//   fieldp_out       out  read field pointer to pattern buffer
//   fieldwp_out      out  write field pointer to pattern buffer
//   field_in_out     out  write data to pattern buffer
//   field_write_out  out  write strobe, one cycle per write
//   field_byte_in    in   read data from pattern buffer
//   host_grant_cnt   out  (PATBUF_ARB_STATS_EN) saturating host grant count
//   host_force_cnt   out  (PATBUF_ARB_STATS_EN) saturating forced grant count
// Macro       : PATBUF_ARB_STATS_EN adds the two statistics counters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module patbuf_access_arbiter #(
  parameter int BUFFER_SIZE  = patbuf_pkg::BUFFER_SIZE,
  parameter int NO_BUFS      = patbuf_pkg::NO_BUFS,
  parameter int BUFFER_WIDTH = patbuf_pkg::BUFFER_WIDTH,
  parameter int READ_LATENCY = 2,
  parameter int MAX_WAIT     = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  patbuf_access_arbiter_if.slave  core,
  patbuf_access_arbiter_if.slave  host,
  output logic                    range_err,
  output logic [2:0]              bufp_out,
  output logic [4:0]              fieldp_out,
  output logic [4:0]              fieldwp_out,
  output logic [BUFFER_WIDTH-1:0] field_in_out,
  output logic                    field_write_out,
  input  logic [BUFFER_WIDTH-1:0] field_byte_in
`ifdef PATBUF_ARB_STATS_EN
  ,
  output logic [15:0]             host_grant_cnt,
  output logic [15:0]             host_force_cnt
`endif
);

  import patbuf_pkg::*;

  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0]       wait_cnt;
  logic                    wait_expired;
  logic                    core_gnt;
  logic                    host_gnt;
  logic                    any_gnt;
  logic                    sel_we;
  logic [2:0]              sel_buf;
  logic [4:0]              sel_field;
  logic [BUFFER_WIDTH-1:0] sel_wdata;
  logic                    sel_err;
  rtag_t                   tag_in;
  rtag_t                   tag_out;
  logic [BUFFER_WIDTH-1:0] ret_data;

  // Core has priority unless the host has already lost MAX_WAIT cycles.
  always_comb begin
    wait_expired = (wait_cnt == WAIT_MAX);
    host_gnt     = host.req && (!core.req || wait_expired);
    core_gnt     = core.req && !host_gnt;
    any_gnt      = core_gnt || host_gnt;
  end

  assign core.gnt = core_gnt;
  assign host.gnt = host_gnt;

  always_comb begin
    sel_we    = core.we;
    sel_buf   = core.buf_idx;
    sel_field = core.field_idx;
    sel_wdata = core.wdata;
    if (host_gnt) begin
      sel_we    = host.we;
      sel_buf   = host.buf_idx;
      sel_field = host.field_idx;
      sel_wdata = host.wdata;
    end
    sel_err = (32'(sel_buf) >= NO_BUFS) || (32'(sel_field) >= BUFFER_SIZE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (host_gnt) begin
      wait_cnt <= '0;
    end else if (host.req && !wait_expired) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Pointers hold between accesses; an out-of-range access leaves the bus
  // untouched and only raises range_err.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      range_err       <= 1'b0;
      bufp_out        <= '0;
      fieldp_out      <= '0;
      fieldwp_out     <= '0;
      field_in_out    <= '0;
      field_write_out <= 1'b0;
    end else begin
      field_write_out <= 1'b0;
      range_err       <= any_gnt && sel_err;
      if (any_gnt && !sel_err) begin
        bufp_out <= sel_buf;
        if (sel_we) begin
          fieldwp_out     <= sel_field;
          field_in_out    <= sel_wdata;
          field_write_out <= 1'b1;
        end else begin
          fieldp_out <= sel_field;
        end
      end
    end
  end

  // Writes push an invalid tag so every slot advances in lock-step with
  // the buffer read pipeline.
  always_comb begin
    tag_in        = '0;
    tag_in.valid  = any_gnt && !sel_we;
    tag_in.req_id = host_gnt ? REQ_HOST : REQ_CORE;
    tag_in.err    = sel_err;
  end

  patbuf_rtag_pipe #(
    .DEPTH   (READ_LATENCY + 1)
  ) u_rtag_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  always_comb begin
    ret_data    = tag_out.err ? '0 : field_byte_in;
    core.rvalid = tag_out.valid && (tag_out.req_id == REQ_CORE);
    host.rvalid = tag_out.valid && (tag_out.req_id == REQ_HOST);
    core.rdata  = core.rvalid ? ret_data : '0;
    host.rdata  = host.rvalid ? ret_data : '0;
  end

`ifdef PATBUF_ARB_STATS_EN
  // A host grant while the core is also requesting can only be a forced one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      host_grant_cnt <= '0;
      host_force_cnt <= '0;
    end else begin
      if (host_gnt && (host_grant_cnt != 16'hFFFF)) begin
        host_grant_cnt <= host_grant_cnt + 16'd1;
      end
      if (host_gnt && core.req && (host_force_cnt != 16'hFFFF)) begin
        host_force_cnt <= host_force_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_patbuf_access_arbiter.sv
//==============================================================================
// Module      : tb_patbuf_access_arbiter
// Description : Self-checking bench for patbuf_access_arbiter with a small
//               pattern-buffer model (2-cycle read latency) on the bus side.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_patbuf_access_arbiter;

  import patbuf_pkg::*;

  localparam int BW = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  patbuf_access_arbiter_if #(.BUFFER_WIDTH(BW)) core_if ();
  patbuf_access_arbiter_if #(.BUFFER_WIDTH(BW)) host_if ();

  logic          range_err;
  logic [2:0]    bufp_out;
  logic [4:0]    fieldp_out;
  logic [4:0]    fieldwp_out;
  logic [BW-1:0] field_in_out;
  logic          field_write_out;
  logic [BW-1:0] field_byte_in;
`ifdef PATBUF_ARB_STATS_EN
  logic [15:0]   host_grant_cnt;
  logic [15:0]   host_force_cnt;
`endif

  patbuf_access_arbiter dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .core            (core_if),
    .host            (host_if),
    .range_err       (range_err),
    .bufp_out        (bufp_out),
    .fieldp_out      (fieldp_out),
    .fieldwp_out     (fieldwp_out),
    .field_in_out    (field_in_out),
    .field_write_out (field_write_out),
    .field_byte_in   (field_byte_in)
`ifdef PATBUF_ARB_STATS_EN
    ,
    .host_grant_cnt  (host_grant_cnt),
    .host_force_cnt  (host_force_cnt)
`endif
  );

  // Pattern buffer model: contents preloaded on the first edge, reads
  // delivered two cycles after the pointer cycle.
  logic [BW-1:0] mem [0:7][0:31];
  logic [BW-1:0] rd1 = '0;
  logic [BW-1:0] rd2 = '0;

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int b = 0; b < 8; b++) begin
        for (int f = 0; f < 32; f++) begin
          mem[b][f] <= 8'(b * 16 + f);
        end
      end
      mem[2][5] <= 8'hA5;
      mem[0][0] <= 8'h11;
      mem[0][1] <= 8'h22;
    end else if (field_write_out) begin
      mem[bufp_out][fieldwp_out] <= field_in_out;
    end
    rd1 <= mem[bufp_out][fieldp_out];
    rd2 <= rd1;
  end

  assign field_byte_in = rd2;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit            id;
    logic [BW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb[$];
  logic [BW-1:0] core_exp = '0;
  logic [BW-1:0] host_exp = '0;

  // Monitor: retire responses first, then record reads granted this cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset_n) begin
      if (core_if.gnt || host_if.gnt) begin
        check("single_gnt", 32'(core_if.gnt & host_if.gnt), 32'd0);
      end
      if (core_if.rvalid || host_if.rvalid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rvalid: core_rvalid=%0b host_rvalid=%0b with no read outstanding (cycle %0d)",
                   core_if.rvalid, host_if.rvalid, cyc);
        end else begin
          e = sb.pop_front();
          check("rv_requester", {core_if.rvalid, host_if.rvalid}, e.id ? 32'd1 : 32'd2);
          check("rv_data", e.id ? host_if.rdata : core_if.rdata, e.data);
          check("rv_other_rdata", e.id ? core_if.rdata : host_if.rdata, 32'd0);
          check("rv_cycle", cyc, e.due);
        end
      end
      if (core_if.gnt && !core_if.we) sb.push_back('{1'b0, core_exp, cyc + 3});
      if (host_if.gnt && !host_if.we) sb.push_back('{1'b1, host_exp, cyc + 3});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge; returns #1 after the edge following gnt.
  task automatic issue(input bit is_host, input bit we, input logic [2:0] b,
                       input logic [4:0] f, input logic [BW-1:0] wd,
                       input logic [BW-1:0] ex, output int gcyc);
    if (is_host) begin
      host_if.req = 1'b1; host_if.we = we; host_if.buf_idx = b;
      host_if.field_idx = f; host_if.wdata = wd; host_exp = ex;
    end else begin
      core_if.req = 1'b1; core_if.we = we; core_if.buf_idx = b;
      core_if.field_idx = f; core_if.wdata = wd; core_exp = ex;
    end
    gcyc = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (is_host ? host_if.gnt : core_if.gnt) begin
        gcyc = cyc;
        break;
      end
    end
    if (gcyc < 0) begin
      total++;
      bad++;
      $display("FAIL gnt_timeout: no grant within 20 cycles for %s request", is_host ? "host" : "core");
    end
    step();
    if (is_host) host_if.req = 1'b0;
    else         core_if.req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int g2;
    core_if.req = 0; core_if.we = 0; core_if.buf_idx = 0; core_if.field_idx = 0; core_if.wdata = 0;
    host_if.req = 0; host_if.we = 0; host_if.buf_idx = 0; host_if.field_idx = 0; host_if.wdata = 0;
    reset_n = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_bufp", bufp_out, 0);
    check("rst_fieldp", fieldp_out, 0);
    check("rst_fieldwp", fieldwp_out, 0);
    check("rst_field_in", field_in_out, 0);
    check("rst_write", field_write_out, 0);
    check("rst_range_err", range_err, 0);
    check("rst_rvalid", {core_if.rvalid, host_if.rvalid}, 0);
    reset_n = 1'b1;
    step();

    // Core read buf 2 field 5 -> 0xA5
    issue(1'b0, 1'b0, 3'd2, 5'd5, 8'h00, 8'hA5, g);
    check("t1_bufp", bufp_out, 2);
    check("t1_fieldp", fieldp_out, 5);
    check("t1_range_err", range_err, 0);
    check("t1_write", field_write_out, 0);
    repeat (4) step();

    // Both request continuously: host forced through on the 5th cycle
    core_if.req = 1; core_if.we = 0; core_if.buf_idx = 0; core_if.field_idx = 0; core_exp = 8'h11;
    host_if.req = 1; host_if.we = 0; host_if.buf_idx = 0; host_if.field_idx = 1; host_exp = 8'h22;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("t2_host_gnt", host_if.gnt, 32'((k == 4) || (k == 9)));
      check("t2_core_gnt", core_if.gnt, 32'(!((k == 4) || (k == 9))));
    end
    step();
    core_if.req = 0;
    host_if.req = 0;
    repeat (5) step();

    // Host write then immediate core read of the same field
    issue(1'b1, 1'b1, 3'd1, 5'd17, 8'h3C, 8'h00, g);
    check("t3_write", field_write_out, 1);
    check("t3_fieldwp", fieldwp_out, 17);
    check("t3_field_in", field_in_out, 8'h3C);
    check("t3_bufp", bufp_out, 1);
    issue(1'b0, 1'b0, 3'd1, 5'd17, 8'h00, 8'h3C, g2);
    check("t3_back_to_back", g2, g + 1);
    check("t3_write_pulse_end", field_write_out, 0);
    check("t3_fieldp", fieldp_out, 17);
    repeat (4) step();

    // Out-of-range core read: granted, no bus change, zero data
    issue(1'b0, 1'b0, 3'd2, 5'd18, 8'h00, 8'h00, g);
    check("t4_range_err", range_err, 1);
    check("t4_bufp_hold", bufp_out, 1);
    check("t4_fieldp_hold", fieldp_out, 17);
    check("t4_write", field_write_out, 0);
    step();
    check("t4_range_err_pulse", range_err, 0);
    repeat (4) step();

    // Alternating core/host reads every cycle
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) begin
        host_if.req = 0;
        core_if.req = 1; core_if.we = 0; core_if.buf_idx = 3; core_if.field_idx = 5'(k);
        core_exp = 8'(8'h30 + k);
      end else begin
        core_if.req = 0;
        host_if.req = 1; host_if.we = 0; host_if.buf_idx = 4; host_if.field_idx = 5'(k);
        host_exp = 8'(8'h40 + k);
      end
      @(negedge clk);
      check("t5_gnt", (k % 2 == 0) ? core_if.gnt : host_if.gnt, 1);
      step();
    end
    core_if.req = 0;
    host_if.req = 0;
    repeat (5) step();

    // Reset with two reads in flight and a write strobe on the bus
    core_if.req = 1; core_if.we = 0; core_if.buf_idx = 3; core_if.field_idx = 1; core_exp = 8'h31;
    step();
    core_if.req = 0;
    host_if.req = 1; host_if.we = 0; host_if.buf_idx = 4; host_if.field_idx = 2; host_exp = 8'h42;
    step();
    host_if.req = 0;
    core_if.req = 1; core_if.we = 1; core_if.buf_idx = 5; core_if.field_idx = 3; core_if.wdata = 8'h77;
    step();
    core_if.req = 0;
    core_if.we = 0;
    check("t6_write_before_rst", field_write_out, 1);
    reset_n = 1'b0;
    #1;
    sb.delete();
    check("t6_write", field_write_out, 0);
    check("t6_bufp", bufp_out, 0);
    check("t6_fieldp", fieldp_out, 0);
    check("t6_fieldwp", fieldwp_out, 0);
    check("t6_field_in", field_in_out, 0);
    check("t6_range_err", range_err, 0);
    check("t6_rvalid", {core_if.rvalid, host_if.rvalid}, 0);
    repeat (2) step();
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t6_no_rvalid", {core_if.rvalid, host_if.rvalid}, 0);
    end
    step();

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/patbuf_access_arbiter.md
Name: patbuf_access_arbiter

Overview:
- Shares the single field read/write port of the pattern buffer between two requesters:
  - the pat core (normal priority path);
  - the host configuration loader (starvation-protected).
- Arbitrates each cycle, drives registered bus outputs into the pattern buffer, range-checks every access, and routes read data back to the requester that issued it.
- Sits between the pat core/loader and the pattern buffer.

Parameters:
- BUFFER_SIZE, 18, fields per buffer; legal field index 0..BUFFER_SIZE-1
- NO_BUFS, 8, number of buffers; legal buffer index 0..NO_BUFS-1
- BUFFER_WIDTH, 8, data width
- READ_LATENCY, 2, cycles from bus-output cycle to valid field_byte_in
- MAX_WAIT, 4, consecutive lost host cycles before host is forced through

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- core_req / host_req  in  1  request; hold request and payload stable until gnt
- core_we / host_we  in  1  1=write, 0=read
- core_buf / host_buf  in  3  buffer index
- core_field / host_field  in  5  field index
- core_wdata / host_wdata  in  BUFFER_WIDTH  write data
- core_gnt / host_gnt  out  1  combinational grant; request is consumed in this cycle
- core_rvalid / host_rvalid  out  1  read data valid, 1-cycle pulse
- core_rdata / host_rdata  out  BUFFER_WIDTH  read data
- range_err  out  1  registered pulse: the granted access was out of range
- bufp_out  out  3  to buffer bufp_in
- fieldp_out  out  5  to buffer fieldp_in
- fieldwp_out  out  5  to buffer fieldwp_in
- field_in_out  out  BUFFER_WIDTH  to buffer field_in_in
- field_write_out  out  1  to buffer field_write_in
- field_byte_in  in  BUFFER_WIDTH  from buffer field_byte_out

Behaviour:
- Reset values: all outputs 0; wait counter 0; return pipeline empty.
- Arbitration, combinational in cycle N:
  - host wins if host_req && (!core_req || wait_cnt==MAX_WAIT);
  - otherwise core wins if core_req.
  - At most one gnt per cycle.
- wait_cnt, width clog2(MAX_WAIT+1):
  - increments when host_req && !host_gnt, saturating at MAX_WAIT;
  - clears on host_gnt;
  - holds when host_req is low.
- Bus outputs are registered at the end of cycle N and visible in N+1:
  - bufp_out <= buf;
  - read: fieldp_out <= field;
  - write: fieldwp_out <= field, field_in_out <= wdata, field_write_out=1 for exactly one cycle.
  - With no grant: field_write_out=0; the pointer outputs hold their last values.
- Range check: buf>=NO_BUFS or field>=BUFFER_SIZE.
  - The access is still granted, but no bus update and no write occur.
  - range_err pulses in N+1.
  - If it was a read, rvalid still fires at the normal latency with rdata=0.
- Read return:
  - A tag pipeline of depth READ_LATENCY+1 carries {valid, requester, err}.
  - The issuing requester's rvalid pulses exactly READ_LATENCY+1 cycles after its gnt cycle (N+3 by default).
  - rdata = field_byte_in in that cycle (combinational pass-through, 0 if err); the other requester's rdata is 0.
- Back-to-back reads every cycle are supported; return order equals grant order.
- Writes return nothing and do not occupy the rvalid slot.
- Read issued in the cycle after a write to the same field: returns the new data; the buffer ordering guarantees this and no forwarding is needed.
- Asynchronous reset mid-operation: pending reads are dropped (no rvalid after release) and field_write_out drops immediately.

Optional Feature:
- Macro PATBUF_ARB_STATS_EN.
- Defined:
  - adds output host_grant_cnt (16b): counts host grants, saturating;
  - adds output host_force_cnt (16b): counts grants forced by MAX_WAIT, saturating;
  - both cleared by reset.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Shared package patbuf_pkg holds:
  - BUFFER_SIZE, NO_BUFS, BUFFER_WIDTH defaults;
  - requester ID constants (REQ_CORE=0, REQ_HOST=1);
  - the read-tag struct {valid, req_id, err}.
- One sub-module, patbuf_rtag_pipe, is a parameterised-depth tag shift register with reset; the arbiter instantiates it once.

Test Plan:
- Core read buf=2, field=5 (buffer holds 0xA5), no host request -> core_gnt in cycle 0; bufp_out=2, fieldp_out=5 in cycle 1; core_rvalid=1 with core_rdata=0xA5 in cycle 3; host_rvalid stays 0.
- Core requests continuously while host holds a request -> host_gnt exactly on the 5th cycle (wait_cnt=4); wait_cnt then returns to 0; core is denied that one cycle only.
- Host write buf=1, field=17, data=0x3C -> field_write_out=1 for one cycle with fieldwp_out=17, field_in_out=0x3C; a subsequent read of that field returns 0x3C.
- Core read field=18 -> gnt given; range_err pulses the next cycle; no bus change; core_rvalid fires at cycle 3 with rdata=0.
- Alternating core/host reads on every cycle for 10 cycles -> each rvalid goes to the correct requester, in order, 3 cycles after its grant.
- Assert reset_n low while 2 reads are in flight -> all outputs 0 immediately; no rvalid after reset is released.
